cfa_equ_scheduler: RTL and testbench

- Raster-scan controller for the CFA demosaic equation bank (RB-at-diagonal, G-interpolation and related equation pipelines).
- Accepts one Bayer pixel per handshake and tracks column/row position and the CFA phase of the centre pixel.
- Flags border pixels whose 5x5 window is incomplete.
- Drives the datapath clock-enable and delays all control so it arrives aligned with the equation-bank result.

---
 rtl/cfa_pkg.sv | 39 +++
 rtl/cfa_ctrl_delay_line.sv | 58 +++++
 rtl/cfa_equ_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_cfa_equ_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_pkg.sv
// ---------------------------------------------------------------------------
// cfa_pkg
// Shared definitions for the CFA demosaic equation-bank scheduler:
//   - centre-pixel phase codes (R, Gr, Gb, B)
//   - Bayer pattern codes as presented on cfg_bayer
//   - scheduler FSM state encoding
//   - width of the control bundle that travels alongside the equation bank
// ---------------------------------------------------------------------------
package cfa_pkg;

   typedef enum logic [1:0] {
      PH_R  = 2'd0,
      PH_GR = 2'd1,
      PH_GB = 2'd2,
      PH_B  = 2'd3
   } phase_t;

   typedef enum logic [1:0] {
      BAYER_RGGB = 2'd0,
      BAYER_GRBG = 2'd1,
      BAYER_GBRG = 2'd2,
      BAYER_BGGR = 2'd3
   } bayer_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   // Flag portion of the control bundle: phase(2) + border + sof + eol + eof.
   localparam int CTRL_FLAG_W = 6;

   // Full bundle width: flags followed by column and row coordinates.
   function automatic int ctrl_bundle_w(input int cnt_w);
      return CTRL_FLAG_W + 2 * cnt_w;
   endfunction

endpackage

// File: rtl/cfa_ctrl_delay_line.sv
// ---------------------------------------------------------------------------
// cfa_ctrl_delay_line
// Enable-gated shift register that carries the per-pixel control bundle so
// it emerges in step with the equation-bank result. Every stage has its own
// valid bit; when en is low every stage holds.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   en            shift enable (shared with the equation-bank registers)
//   in_valid      valid bit loaded into stage 0
//   in_data       bundle loaded into stage 0
//   out_valid     valid bit of the last stage
//   out_data      bundle of the last stage
//   any_valid     at least one stage holds a valid entry
// ---------------------------------------------------------------------------
module cfa_ctrl_delay_line
   import cfa_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             any_valid
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   // Stage 0 takes the new entry, later stages take their predecessor.
   // Nothing moves without en, so a downstream stall freezes the whole line
   // and no entry is lost or duplicated.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
      end else if (en) begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign any_valid = |valid_q;

endmodule

// File: rtl/cfa_equ_scheduler.sv
// ---------------------------------------------------------------------------
// cfa_equ_scheduler
// Raster-scan controller for the CFA demosaic equation bank. Accepts one
// Bayer pixel per handshake, tracks its column/row and CFA phase, flags
// pixels whose 5x5 window is incomplete, and delays all of that control so
// it lines up with the equation-bank result EQU_LAT enabled cycles later.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   in_valid, in_sof         upstream pixel valid and start-of-frame
//   in_ready                 pixel accepted when in_valid & in_ready
//   cfg_bayer                pattern code, sampled on an accepted sof
//   equ_en                   clock enable for the equation-bank registers
//   out_valid, out_ready     aligned result handshake
//   out_phase, out_border    centre colour and incomplete-window flag
//   out_sof/eol/eof          frame/line markers aligned with out_valid
//   out_col, out_row         coordinates of the output pixel
//   frame_done               pulse once the last output of a frame has left
//   err_sof                  pulse when sof arrives in the middle of a frame
// ---------------------------------------------------------------------------
module cfa_equ_scheduler
   import cfa_pkg::*;
#(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int CNT_W   = 11,
   parameter int EQU_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   input  logic [1:0]       cfg_bayer,
   output logic             equ_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_phase,
   output logic             out_border,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic [CNT_W-1:0] out_col,
   output logic [CNT_W-1:0] out_row,
   output logic             frame_done,
   output logic             err_sof
);

   localparam int BUNDLE_W = ctrl_bundle_w(CNT_W);

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] COL_HI   = CNT_W'(IMG_W - 3);
   localparam logic [CNT_W-1:0] ROW_HI   = CNT_W'(IMG_H - 3);
   localparam logic [CNT_W-1:0] EDGE_LO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    col_q;
   logic [CNT_W-1:0]    col_d;
   logic [CNT_W-1:0]    row_q;
   logic [CNT_W-1:0]    row_d;
   logic [1:0]          pattern_q;
   logic [1:0]          pattern_d;

   logic                advance;
   logic                accept;
   logic                issue;
   logic [CNT_W-1:0]    cur_col;
   logic [CNT_W-1:0]    cur_row;
   logic [1:0]          cur_pattern;
   logic [1:0]          cur_phase;
   logic                cur_border;
   logic                last_col;
   logic                last_pix;
   logic [CNT_W-1:0]    next_col;
   logic [CNT_W-1:0]    next_row;
   logic [BUNDLE_W-1:0] issue_bundle;
   logic [BUNDLE_W-1:0] dl_data;
   logic                dl_valid;
   logic                any_valid;

   // The whole pipeline moves together: it may advance whenever the output
   // slot is empty or being taken. During FLUSH no new pixel is taken so the
   // frame can drain cleanly.
   assign advance  = out_ready | ~dl_valid;
   assign equ_en   = advance;
   assign in_ready = advance & (state_q != ST_FLUSH);
   assign accept   = in_valid & in_ready;

   // The counters hold the position the next pixel will occupy. A sof pixel
   // always lands on (0,0) and uses the pattern presented with it, so the
   // restart pixel is coded correctly in the same cycle it is accepted.
   assign cur_col     = in_sof ? '0 : col_q;
   assign cur_row     = in_sof ? '0 : row_q;
   assign cur_pattern = in_sof ? cfg_bayer : pattern_q;

   // Raster stepping, phase and 5x5 window-completeness for the pixel being
   // issued this cycle. Phase is the position parity folded through the
   // Bayer pattern code, which works because the four codes are arranged as
   // the XOR offsets of their top-left colour.
   assign last_col   = (cur_col == COL_LAST);
   assign last_pix   = last_col & (cur_row == ROW_LAST);
   assign next_col   = last_col ? '0 : cur_col + ONE;
   assign next_row   = last_col ? cur_row + ONE : cur_row;
   assign cur_phase  = {cur_row[0], cur_col[0]} ^ cur_pattern;
   assign cur_border = (cur_row < EDGE_LO) | (cur_row > ROW_HI) |
                       (cur_col < EDGE_LO) | (cur_col > COL_HI);

   assign issue_bundle = {cur_phase, cur_border, in_sof, last_col, last_pix,
                          cur_col, cur_row};

   // State, position and latched pattern registers. Reset drops any frame
   // in progress; together with the cleared delay line this guarantees no
   // frame_done for an aborted frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         col_q     <= '0;
         row_q     <= '0;
         pattern_q <= '0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         pattern_q <= pattern_d;
      end
   end

   // Next-state logic. IDLE waits for a sof and throws away anything else.
   // ACTIVE issues every accepted pixel; a sof here is an error but still
   // restarts the frame, while older pixels keep draining through the delay
   // line. The final raster position sends the FSM to FLUSH, which holds off
   // new input until the delay line is empty and then signals frame_done.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      pattern_d  = pattern_q;
      issue      = 1'b0;
      err_sof    = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept && in_sof) begin
               issue     = 1'b1;
               pattern_d = cfg_bayer;
               col_d     = next_col;
               row_d     = next_row;
               state_d   = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               issue   = 1'b1;
               err_sof = in_sof;
               if (in_sof) begin
                  pattern_d = cfg_bayer;
               end
               if (last_pix) begin
                  col_d   = '0;
                  row_d   = '0;
                  state_d = ST_FLUSH;
               end else begin
                  col_d = next_col;
                  row_d = next_row;
               end
            end
         end
         ST_FLUSH: begin
            if (!any_valid) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   cfa_ctrl_delay_line #(
      .DEPTH (EQU_LAT),
      .WIDTH (BUNDLE_W)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .in_valid  (issue),
      .in_data   (issue_bundle),
      .out_valid (dl_valid),
      .out_data  (dl_data),
      .any_valid (any_valid)
   );

   assign out_valid = dl_valid;
   assign {out_phase, out_border, out_sof, out_eol, out_eof, out_col, out_row} = dl_data;

endmodule

// File: tb/tb_cfa_equ_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cfa_equ_scheduler
// Directed bench for cfa_equ_scheduler on a 6x5 image with a two-stage
// equation bank. Expected per-pixel values are hand-computed in a table.
// ---------------------------------------------------------------------------
module tb_cfa_equ_scheduler;
   import cfa_pkg::*;

   localparam int W    = 6;
   localparam int H    = 5;
   localparam int CW   = 11;
   localparam int LAT  = 2;
   localparam int NPIX = W * H;
   localparam int CAPN = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [1:0]    cfg_bayer = 2'd0;
   logic          out_ready;
   logic          in_ready;
   logic          equ_en;
   logic          out_valid;
   logic [1:0]    out_phase;
   logic          out_border;
   logic          out_sof;
   logic          out_eol;
   logic          out_eof;
   logic [CW-1:0] out_col;
   logic [CW-1:0] out_row;
   logic          frame_done;
   logic          err_sof;

   always #5 clk = ~clk;

   cfa_equ_scheduler #(
      .IMG_W   (W),
      .IMG_H   (H),
      .CNT_W   (CW),
      .EQU_LAT (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_ready   (in_ready),
      .cfg_bayer  (cfg_bayer),
      .equ_en     (equ_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_phase  (out_phase),
      .out_border (out_border),
      .out_sof    (out_sof),
      .out_eol    (out_eol),
      .out_eof    (out_eof),
      .out_col    (out_col),
      .out_row    (out_row),
      .frame_done (frame_done),
      .err_sof    (err_sof)
   );

   typedef struct {
      logic [1:0] pat;
      int         col;
      int         row;
      logic [1:0] ph;
      logic       bd;
      logic       sf;
      logic       el;
      logic       ef;
      string      nm;
   } vec_t;

   vec_t vecs[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Free-running cycle counter used to time-stamp accepts and outputs.
   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: 0 = always high, 1 = always low, 2 = toggle every 3.
   int ready_mode = 0;
   int tog_cnt    = 0;
   initial out_ready = 1'b1;
   always @(posedge clk) begin
      #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'b0;
      else begin
         tog_cnt++;
         if (tog_cnt >= 3) begin
            tog_cnt   = 0;
            out_ready = ~out_ready;
         end
      end
   end

   // Output monitor: records every transferred result, counts event pulses
   // and watches that a stalled output holds still with input blocked.
   logic [CW-1:0] cap_col [CAPN];
   logic [CW-1:0] cap_row [CAPN];
   logic [1:0]    cap_phase [CAPN];
   logic          cap_border [CAPN];
   logic          cap_sof [CAPN];
   logic          cap_eol [CAPN];
   logic          cap_eof [CAPN];
   int            cap_cyc [CAPN];
   int            cap_n = 0;
   int            fd_cnt = 0;
   int            fd_cyc = 0;
   int            err_cnt = 0;
   int            err_cyc = 0;
   int            stall_checks = 0;
   int            stall_fail = 0;
   logic          prev_stall = 1'b0;
   logic [27:0]   prev_bundle = '0;
   logic [27:0]   cur_bundle;

   assign cur_bundle = {out_phase, out_border, out_sof, out_eol, out_eof, out_col, out_row};

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (out_valid && out_ready && cap_n < CAPN) begin
            cap_col[cap_n]    = out_col;
            cap_row[cap_n]    = out_row;
            cap_phase[cap_n]  = out_phase;
            cap_border[cap_n] = out_border;
            cap_sof[cap_n]    = out_sof;
            cap_eol[cap_n]    = out_eol;
            cap_eof[cap_n]    = out_eof;
            cap_cyc[cap_n]    = cyc;
            cap_n++;
         end
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (err_sof) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (prev_stall) begin
            stall_checks++;
            if (cur_bundle !== prev_bundle || !out_valid) stall_fail++;
         end
         if (out_valid && !out_ready && (in_ready || equ_en)) stall_fail++;
         prev_stall  = out_valid && !out_ready;
         prev_bundle = cur_bundle;
      end
   end

   int acc_cyc [CAPN];
   int acc_n = 0;

   // Single comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Offer one pixel and hold it until the DUT takes it.
   task automatic applyStimulus(input logic sof);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_sof   = sof;
      for (int w = 0; w < 20 && !done; w++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            if (acc_n < CAPN) acc_cyc[acc_n] = cyc;
            acc_n++;
         end
         @(posedge clk);
         #1;
      end
      in_sof = 1'b0;
      if (!done) checkOutput("push_timeout", 64'd0, 64'd1);
   endtask

   // Stream n pixels back-to-back; pixel 0 and pixel sof2 carry sof.
   task automatic sendPixels(input int n, input int sof2);
      for (int k = 0; k < n; k++) applyStimulus(k == 0 || k == sof2);
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for one frame_done and make sure no second one follows.
   task automatic waitDone(input string name, input int fdb, input int budget);
      for (int i = 0; i < budget && fd_cnt == fdb; i++) @(negedge clk);
      checkOutput({name, "_frame_done"}, 64'(fd_cnt - fdb), 64'd1);
      repeat (5) @(negedge clk);
      checkOutput({name, "_done_single"}, 64'(fd_cnt - fdb), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Full-frame checks: raster order from base, then the table entries.
   task automatic checkFrame(input string name, input int base, input logic [1:0] pat);
      int idx;
      for (int i = 0; i < NPIX; i++) begin
         checkOutput($sformatf("%s_raster_%0d", name, i),
                     {42'd0, cap_col[base+i], cap_row[base+i]},
                     {42'd0, CW'(i % W), CW'(i / W)});
      end
      foreach (vecs[v]) begin
         if (vecs[v].pat == pat) begin
            idx = base + vecs[v].row * W + vecs[v].col;
            checkOutput({name, "_", vecs[v].nm},
                        {59'd0, cap_phase[idx], cap_border[idx], cap_sof[idx], cap_eol[idx], cap_eof[idx]},
                        {59'd0, vecs[v].ph, vecs[v].bd, vecs[v].sf, vecs[v].el, vecs[v].ef});
         end
      end
   endtask

   task automatic addVec(input logic [1:0] pat, input int col, input int row, input logic [1:0] ph,
                         input logic bd, input logic sf, input logic el, input logic ef, input string nm);
      vec_t v;
      v.pat = pat; v.col = col; v.row = row; v.ph = ph;
      v.bd = bd; v.sf = sf; v.el = el; v.ef = ef; v.nm = nm;
      vecs.push_back(v);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      int fdb;
      int errb;
      int sb;
      int nb;

      // Hand-computed expectations: pattern, col, row, phase, border, sof, eol, eof.
      addVec(2'd0, 0, 0, PH_R,  1'b1, 1'b1, 1'b0, 1'b0, "p0_origin");
      addVec(2'd0, 1, 1, PH_B,  1'b1, 1'b0, 1'b0, 1'b0, "p0_c1r1");
      addVec(2'd0, 2, 2, PH_R,  1'b0, 1'b0, 1'b0, 1'b0, "p0_c2r2");
      addVec(2'd0, 3, 2, PH_GR, 1'b0, 1'b0, 1'b0, 1'b0, "p0_c3r2");
      addVec(2'd0, 2, 3, PH_GB, 1'b1, 1'b0, 1'b0, 1'b0, "p0_c2r3");
      addVec(2'd0, 5, 0, PH_GR, 1'b1, 1'b0, 1'b1, 1'b0, "p0_eol_r0");
      addVec(2'd0, 5, 4, PH_GR, 1'b1, 1'b0, 1'b1, 1'b1, "p0_last");
      addVec(2'd3, 0, 0, PH_B,  1'b1, 1'b1, 1'b0, 1'b0, "p3_origin");
      addVec(2'd3, 1, 1, PH_R,  1'b1, 1'b0, 1'b0, 1'b0, "p3_c1r1");
      addVec(2'd3, 2, 2, PH_B,  1'b0, 1'b0, 1'b0, 1'b0, "p3_c2r2");
      addVec(2'd3, 3, 2, PH_GB, 1'b0, 1'b0, 1'b0, 1'b0, "p3_c3r2");
      addVec(2'd3, 4, 2, PH_B,  1'b1, 1'b0, 1'b0, 1'b0, "p3_c4r2");
      addVec(2'd3, 1, 2, PH_GB, 1'b1, 1'b0, 1'b0, 1'b0, "p3_c1r2");
      addVec(2'd3, 5, 4, PH_GB, 1'b1, 1'b0, 1'b1, 1'b1, "p3_last");

      $display("[TB] reset");
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid",  64'(out_valid),  64'd0);
      checkOutput("rst_in_ready",   64'(in_ready),   64'd1);
      checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
      checkOutput("rst_err_sof",    64'(err_sof),    64'd0);
      checkOutput("rst_equ_en",     64'(equ_en),     64'd1);
      @(posedge clk);
      #1;

      $display("[TB] frame RGGB, continuous");
      base = cap_n; fdb = fd_cnt; acc_n = 0;
      cfg_bayer = 2'd0;
      sendPixels(NPIX, -1);
      waitDone("t1", fdb, 100);
      checkOutput("t1_count", 64'(cap_n - base), 64'(NPIX));
      checkFrame("t1", base, 2'd0);
      for (int i = 0; i < NPIX; i++) begin
         checkOutput($sformatf("t1_latency_%0d", i), 64'(cap_cyc[base+i] - acc_cyc[i]), 64'(LAT));
      end
      checkOutput("t1_done_timing", 64'(fd_cyc), 64'(cap_cyc[base+NPIX-1] + 1));

      $display("[TB] frame BGGR");
      base = cap_n; fdb = fd_cnt; acc_n = 0;
      cfg_bayer = 2'd3;
      sendPixels(NPIX, -1);
      waitDone("t2", fdb, 100);
      cfg_bayer = 2'd0;
      checkOutput("t2_count", 64'(cap_n - base), 64'(NPIX));
      checkFrame("t2", base, 2'd3);
      nb = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (!cap_border[base+i] && cap_row[base+i] == CW'(2)) nb++;
      end
      checkOutput("t2_inner_row2", 64'(nb), 64'd2);
      nb = 0;
      for (int i = 0; i < NPIX; i++) if (!cap_border[base+i]) nb++;
      checkOutput("t2_inner_total", 64'(nb), 64'd2);

      $display("[TB] frame RGGB, toggling out_ready");
      base = cap_n; fdb = fd_cnt; acc_n = 0; sb = stall_checks;
      ready_mode = 2;
      sendPixels(NPIX, -1);
      waitDone("t3", fdb, 300);
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("t3_count", 64'(cap_n - base), 64'(NPIX));
      checkFrame("t3", base, 2'd0);
      checkOutput("t3_stalls_seen", 64'(stall_checks > sb), 64'd1);
      checkOutput("t3_stall_hold", 64'(stall_fail), 64'd0);

      $display("[TB] sof injected at pixel 14");
      base = cap_n; fdb = fd_cnt; errb = err_cnt; acc_n = 0;
      sendPixels(14 + NPIX, 14);
      waitDone("t4", fdb, 100);
      checkOutput("t4_count", 64'(cap_n - base), 64'(14 + NPIX));
      checkOutput("t4_err_pulses", 64'(err_cnt - errb), 64'd1);
      checkOutput("t4_err_timing", 64'(err_cyc), 64'(acc_cyc[14]));
      for (int i = 0; i < 14; i++) begin
         checkOutput($sformatf("t4_partial_%0d", i),
                     {42'd0, cap_col[base+i], cap_row[base+i]},
                     {42'd0, CW'(i % W), CW'(i / W)});
      end
      checkOutput("t4_partial_no_eof", 64'(cap_eof[base+13]), 64'd0);
      checkFrame("t4", base + 14, 2'd0);

      $display("[TB] leading pixels without sof");
      base = cap_n; fdb = fd_cnt; acc_n = 0;
      for (int k = 0; k < 3; k++) applyStimulus(1'b0);
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t5_dropped", 64'(cap_n - base), 64'd0);
      acc_n = 0;
      sendPixels(NPIX, -1);
      waitDone("t5", fdb, 100);
      checkOutput("t5_count", 64'(cap_n - base), 64'(NPIX));
      checkFrame("t5", base, 2'd0);

      $display("[TB] reset mid-frame");
      fdb = fd_cnt; acc_n = 0;
      for (int k = 0; k < 10; k++) applyStimulus(k == 0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_out_valid", 64'(out_valid), 64'd0);
      checkOutput("t6_in_ready",  64'(in_ready),  64'd1);
      repeat (10) @(negedge clk);
      checkOutput("t6_no_done", 64'(fd_cnt - fdb), 64'd0);
      checkOutput("t6_idle_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      base = cap_n; fdb = fd_cnt; acc_n = 0;
      sendPixels(NPIX, -1);
      waitDone("t6", fdb, 100);
      checkOutput("t6_count", 64'(cap_n - base), 64'(NPIX));
      checkFrame("t6", base, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
